// File: rtl/rf_pkg.sv
// Shared types and default sizes for the multiport register file.
package rf_pkg;

    localparam int RF_DATA_W = 16;
    localparam int RF_ADDR_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DUMP = 2'd1,
        DONE = 2'd2
    } dump_state_t;

endpackage

// File: rtl/rf_dump_seq.sv
// Debug dump sequencer: on halt, walks the register index space once,
// one index per cycle, then parks in DONE until reset.
module rf_dump_seq
    import rf_pkg::*;
#(
    parameter int ADDR_W   = RF_ADDR_W,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hlt_i,
    output logic [ADDR_W-1:0] ptr_o,
    output logic              issue_o,
    output logic              dump_valid_o,
    output logic              dump_done_o
);

    // One extra pointer bit so the terminal compare never wraps to zero.
    localparam int              PTR_W     = ADDR_W + 1;
    localparam logic [PTR_W-1:0] PTR_START = ZERO_REG ? PTR_W'(1) : PTR_W'(0);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'((1 << ADDR_W) - 1);

    dump_state_t      state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;

    // State, pointer and status registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its peers, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: a beat is issued every cycle spent in DUMP.
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        valid_d = 1'b0;
        done_d  = done_q;
        unique case (state_q)
            IDLE: begin
                if (hlt_i) begin
                    state_d = DUMP;
                    ptr_d   = PTR_START;
                end
            end
            DUMP: begin
                valid_d = 1'b1;
                if (ptr_q == PTR_LAST) begin
                    state_d = DONE;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            DONE: begin
                done_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ptr_o        = ptr_q[ADDR_W-1:0];
    assign issue_o      = (state_q == DUMP);
    assign dump_valid_o = valid_q;
    assign dump_done_o  = done_q;

endmodule

// File: rtl/rf_multiport.sv
// Multiport register file: NUM_RD registered read ports, one write port with
// same-edge write-to-read bypass, optional hardwired-zero register 0, and a
// halt-triggered debug dump of all register contents.
module rf_multiport
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    input  logic [NUM_RD-1:0]        re,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     we,
    input  logic                     hlt,
    output logic                     dump_valid,
    output logic [ADDR_W-1:0]        dump_addr,
    output logic [DATA_W-1:0]        dump_data,
    output logic                     dump_done
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] seq_ptr;
    logic              seq_issue;
    logic [ADDR_W-1:0] dump_addr_q;
    logic [DATA_W-1:0] dump_data_q;

    // Architectural read value: zero register first, then the in-flight write.
    function automatic logic [DATA_W-1:0] lookup(input logic [ADDR_W-1:0] a);
        if (ZERO_REG && a == '0) begin
            return '0;
        end else if (we && wr_addr == a) begin
            return wr_data;
        end else begin
            return mem_q[a];
        end
    endfunction

    // Storage array write; writes to register 0 are dropped when it is hardwired.
    // NOTE: the array is reset because the architecture requires all registers
    // to read 0 after reset; this forces flops rather than a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we && !(ZERO_REG && wr_addr == '0)) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [DATA_W-1:0] rd_q;

        // Registered read port; a disabled port holds its last value.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_q <= '0;
            end else if (re[i]) begin
                rd_q <= lookup(rd_addr[i*ADDR_W +: ADDR_W]);
            end
        end

        assign rd_data[i*DATA_W +: DATA_W] = rd_q;
    end

    rf_dump_seq #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_dump_seq (
        .clk          (clk),
        .rst_n        (rst_n),
        .hlt_i        (hlt),
        .ptr_o        (seq_ptr),
        .issue_o      (seq_issue),
        .dump_valid_o (dump_valid),
        .dump_done_o  (dump_done)
    );

    // Dump beat registers, aligned with the sequencer's registered valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dump_addr_q <= '0;
            dump_data_q <= '0;
        end else if (seq_issue) begin
            dump_addr_q <= seq_ptr;
            dump_data_q <= lookup(seq_ptr);
        end
    end

    assign dump_addr = dump_addr_q;
    assign dump_data = dump_data_q;

endmodule

// File: tb/tb_rf_multiport.sv
// Self-checking bench for rf_multiport: default build (2 ports, zero reg)
// and a 4-port, 8-entry build without the zero register.
module tb_rf_multiport;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Default build
    logic        rst_n_a;
    logic [7:0]  rd_addr_a;
    logic [1:0]  re_a;
    logic [31:0] rd_data_a;
    logic [3:0]  wr_addr_a;
    logic [15:0] wr_data_a;
    logic        we_a, hlt_a;
    logic        dump_valid_a, dump_done_a;
    logic [3:0]  dump_addr_a;
    logic [15:0] dump_data_a;

    // 4-port, ADDR_W=3, no zero register
    logic        rst_n_b;
    logic [11:0] rd_addr_b;
    logic [3:0]  re_b;
    logic [63:0] rd_data_b;
    logic [2:0]  wr_addr_b;
    logic [15:0] wr_data_b;
    logic        we_b, hlt_b;
    logic        dump_valid_b, dump_done_b;
    logic [2:0]  dump_addr_b;
    logic [15:0] dump_data_b;

    rf_multiport dut_a (
        .clk(clk), .rst_n(rst_n_a),
        .rd_addr(rd_addr_a), .re(re_a), .rd_data(rd_data_a),
        .wr_addr(wr_addr_a), .wr_data(wr_data_a), .we(we_a),
        .hlt(hlt_a), .dump_valid(dump_valid_a), .dump_addr(dump_addr_a),
        .dump_data(dump_data_a), .dump_done(dump_done_a)
    );

    rf_multiport #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n_b),
        .rd_addr(rd_addr_b), .re(re_b), .rd_data(rd_data_b),
        .wr_addr(wr_addr_b), .wr_data(wr_data_b), .we(we_b),
        .hlt(hlt_b), .dump_valid(dump_valid_b), .dump_addr(dump_addr_b),
        .dump_data(dump_data_b), .dump_done(dump_done_b)
    );

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic [1:0]  re;
        logic [3:0]  ra0;
        logic [3:0]  ra1;
        logic [15:0] exp0;
        logic [15:0] exp1;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload_a(input logic [15:0] base);
        for (int n = 0; n < 16; n++) begin
            we_a      = 1'b1;
            wr_addr_a = 4'(n);
            wr_data_a = base + 16'(n);
            tick();
        end
        we_a = 1'b0;
    endtask

    initial begin
        rst_n_a = 1'b0; rd_addr_a = '0; re_a = '0; wr_addr_a = '0;
        wr_data_a = '0; we_a = 1'b0; hlt_a = 1'b0;
        rst_n_b = 1'b0; rd_addr_b = '0; re_b = '0; wr_addr_b = '0;
        wr_data_b = '0; we_b = 1'b0; hlt_b = 1'b0;

        vecs[0] = '{1'b0, 4'd0, 16'h0000, 2'b11, 4'd0, 4'd1, 16'h0000, 16'h0000};
        vecs[1] = '{1'b1, 4'd3, 16'hBEEF, 2'b11, 4'd2, 4'd15, 16'h0000, 16'h0000};
        vecs[2] = '{1'b0, 4'd0, 16'h0000, 2'b01, 4'd3, 4'd3, 16'hBEEF, 16'h0000};
        vecs[3] = '{1'b1, 4'd0, 16'h1234, 2'b11, 4'd0, 4'd3, 16'h0000, 16'hBEEF};
        vecs[4] = '{1'b0, 4'd0, 16'h0000, 2'b11, 4'd0, 4'd0, 16'h0000, 16'h0000};
        vecs[5] = '{1'b1, 4'd5, 16'hA5A5, 2'b11, 4'd5, 4'd5, 16'hA5A5, 16'hA5A5};
        vecs[6] = '{1'b1, 4'd6, 16'h1111, 2'b01, 4'd6, 4'd6, 16'h1111, 16'hA5A5};
        vecs[7] = '{1'b0, 4'd0, 16'h0000, 2'b10, 4'd3, 4'd6, 16'h1111, 16'h1111};
        vecs[8] = '{1'b0, 4'd0, 16'h0000, 2'b11, 4'd5, 4'd3, 16'hA5A5, 16'hBEEF};

        // Reset state
        repeat (2) tick();
        check("rst rd_data_a", rd_data_a, 32'h0);
        check("rst dump_valid_a", 32'(dump_valid_a), 32'h0);
        check("rst dump_done_a", 32'(dump_done_a), 32'h0);
        check("rst dump_addr_a", 32'(dump_addr_a), 32'h0);
        check("rst dump_data_a", 32'(dump_data_a), 32'h0);
        check("rst rd_data_b", rd_data_b[31:0] | rd_data_b[63:32], 32'h0);
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;

        // Every address reads zero after reset on both ports
        re_a = 2'b11;
        for (int a = 0; a < 16; a++) begin
            rd_addr_a = {4'(15 - a), 4'(a)};
            tick();
            check("post-reset read", rd_data_a, 32'h0);
        end
        check("idle dump_valid_a", 32'(dump_valid_a), 32'h0);
        check("idle dump_done_a", 32'(dump_done_a), 32'h0);

        // Table-driven read/write/bypass vectors
        for (int v = 0; v < 9; v++) begin
            we_a      = vecs[v].we;
            wr_addr_a = vecs[v].wa;
            wr_data_a = vecs[v].wd;
            re_a      = vecs[v].re;
            rd_addr_a = {vecs[v].ra1, vecs[v].ra0};
            tick();
            check($sformatf("vec%0d port0", v), 32'(rd_data_a[15:0]), 32'(vecs[v].exp0));
            check($sformatf("vec%0d port1", v), 32'(rd_data_a[31:16]), 32'(vecs[v].exp1));
        end
        we_a = 1'b0;
        re_a = 2'b00;

        // Full dump with a bypassed write on the beat for R9
        preload_a(16'h1000);
        hlt_a = 1'b1;
        tick();
        hlt_a = 1'b0;
        check("dump pre-beat valid", 32'(dump_valid_a), 32'h0);
        for (int c = 1; c < 16; c++) begin
            we_a      = (c == 9);
            wr_addr_a = 4'd9;
            wr_data_a = 16'hCAFE;
            tick();
            we_a = 1'b0;
            check($sformatf("beat%0d valid", c), 32'(dump_valid_a), 32'h1);
            check($sformatf("beat%0d addr", c), 32'(dump_addr_a), 32'(c));
            check($sformatf("beat%0d data", c), 32'(dump_data_a),
                  (c == 9) ? 32'hCAFE : 32'h1000 + 32'(c));
        end
        tick();
        check("dump end valid", 32'(dump_valid_a), 32'h0);
        check("dump end done", 32'(dump_done_a), 32'h1);
        hlt_a = 1'b1;
        tick();
        hlt_a = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("done no beats", 32'(dump_valid_a), 32'h0);
            check("done sticky", 32'(dump_done_a), 32'h1);
        end
        rd_addr_a = {4'd0, 4'd9};
        re_a      = 2'b01;
        tick();
        check("read in DONE", 32'(rd_data_a[15:0]), 32'hCAFE);

        // Second run aborted by reset at beat 4
        rst_n_a = 1'b0;
        tick();
        rst_n_a = 1'b1;
        re_a    = 2'b00;
        preload_a(16'h2000);
        hlt_a = 1'b1;
        tick();
        hlt_a = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check($sformatf("run2 beat%0d addr", c), 32'(dump_addr_a), 32'(c));
            check($sformatf("run2 beat%0d data", c), 32'(dump_data_a), 32'h2000 + 32'(c));
        end
        #1 rst_n_a = 1'b0;
        #1;
        check("abort valid", 32'(dump_valid_a), 32'h0);
        check("abort addr", 32'(dump_addr_a), 32'h0);
        check("abort data", 32'(dump_data_a), 32'h0);
        check("abort done", 32'(dump_done_a), 32'h0);
        check("abort rd_data", rd_data_a, 32'h0);
        rst_n_a   = 1'b1;
        rd_addr_a = {4'd4, 4'd9};
        re_a      = 2'b11;
        tick();
        check("abort regs cleared", rd_data_a, 32'h0);
        re_a = 2'b00;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("abort stays idle", 32'(dump_valid_a), 32'h0);
        end
        hlt_a = 1'b1;
        tick();
        hlt_a = 1'b0;
        tick();
        check("restart valid", 32'(dump_valid_a), 32'h1);
        check("restart addr", 32'(dump_addr_a), 32'h1);
        check("restart data", 32'(dump_data_a), 32'h0);

        // 4-port build: independent addresses, shared-address bypass, hold
        for (int n = 0; n < 8; n++) begin
            we_b      = 1'b1;
            wr_addr_b = 3'(n);
            wr_data_b = 16'(32'h3000 + n * 32'h11);
            tick();
        end
        we_b      = 1'b0;
        rd_addr_b = {3'd2, 3'd5, 3'd0, 3'd7};
        re_b      = 4'hF;
        tick();
        check("b port0", 32'(rd_data_b[15:0]), 32'h3077);
        check("b port1", 32'(rd_data_b[31:16]), 32'h3000);
        check("b port2", 32'(rd_data_b[47:32]), 32'h3055);
        check("b port3", 32'(rd_data_b[63:48]), 32'h3022);
        we_b      = 1'b1;
        wr_addr_b = 3'd4;
        wr_data_b = 16'hBEEF;
        rd_addr_b = {3'd4, 3'd4, 3'd4, 3'd4};
        tick();
        we_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("b bypass port%0d", i), 32'(rd_data_b[i*16 +: 16]), 32'hBEEF);
        end
        rd_addr_b = {3'd1, 3'd1, 3'd1, 3'd1};
        re_b      = 4'b1010;
        tick();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("b partial port%0d", i), 32'(rd_data_b[i*16 +: 16]),
                  (i % 2 == 1) ? 32'h3011 : 32'hBEEF);
        end
        re_b  = 4'h0;
        hlt_b = 1'b1;
        tick();
        hlt_b = 1'b0;
        check("b pre-beat valid", 32'(dump_valid_b), 32'h0);
        for (int c = 0; c < 8; c++) begin
            tick();
            check($sformatf("b beat%0d valid", c), 32'(dump_valid_b), 32'h1);
            check($sformatf("b beat%0d addr", c), 32'(dump_addr_b), 32'(c));
            check($sformatf("b beat%0d data", c), 32'(dump_data_b),
                  (c == 4) ? 32'hBEEF : 32'h3000 + 32'(c) * 32'h11);
        end
        tick();
        check("b end valid", 32'(dump_valid_b), 32'h0);
        check("b end done", 32'(dump_done_b), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rf_multiport.md
Name: rf_multiport

Overview:
- Parametrised successor to the single-cycle 2R/1W register file, intended for the pipelined datapath.
- Provides DATA_W-bit x 2**ADDR_W registers, NUM_RD registered read ports, one write port with write-to-read bypass, and an optional hardwired-zero register 0.
- On halt, a sequencer streams register contents one per cycle on a debug port. This replaces the per-clock $display dump.
- Sits between the decode stage (read) and writeback stage (write).

Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W]
- re  in  NUM_RD  per-port read enable
- rd_data  out  NUM_RD*DATA_W  registered read data; port i occupies bits [i*DATA_W +: DATA_W]
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- we  in  1  write enable
- hlt  in  1  halt request; starts the dump
- dump_valid  out  1  dump_addr/dump_data valid this cycle
- dump_addr  out  ADDR_W  register index being dumped
- dump_data  out  DATA_W  contents of dump_addr
- dump_done  out  1  dump complete; sticky until reset

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers, rd_data, dump_addr and dump_data clear to 0
  - dump_valid and dump_done clear to 0
  - FSM goes to IDLE
- Write:
  - at posedge, if we=1, mem[wr_addr] <= wr_data
  - if ZERO_REG=1 and wr_addr=0, the write is dropped
- Read:
  - latency 1 cycle; at posedge, for each port i with re[i]=1, rd_data[i] <= value(rd_addr[i])
  - re[i]=0: rd_data[i] holds its previous value (power gating, not functional)
- value(a):
  - 0 if ZERO_REG=1 and a=0
  - else wr_data if we=1 and wr_addr=a (bypass: the same-edge write is visible)
  - else mem[a]
- Multiple ports may read the same address in one cycle; each receives the identical value.
- Dump FSM states: IDLE, DUMP, DONE.
  - IDLE -> DUMP when hlt=1 is sampled at posedge; dump pointer loads START = (ZERO_REG ? 1 : 0).
  - DUMP, every cycle:
    - dump_valid=1
    - dump_addr=ptr
    - dump_data=value(ptr), with the same bypass rule
    - all three outputs are registered, driven the cycle after the pointer is set
  - ptr increments each cycle.
  - After the entry at ptr = DEPTH-1 is issued: FSM -> DONE, dump_valid=0 next cycle, dump_done=1.
  - Dump length = DEPTH-START beats, back to back, no gaps.
  - DONE is terminal: hlt is ignored; only rst_n returns the FSM to IDLE.
  - hlt deasserting mid-dump does not abort the dump.
- Reads and writes stay fully functional in every FSM state.
- Reset asserted mid-dump aborts immediately to IDLE with all outputs at their reset values.
- ptr is ADDR_W+1 bits wide so the terminal compare does not wrap.

Decomposition:
- Package rf_pkg:
  - dump_state_t enum {IDLE, DUMP, DONE}
  - default constants RF_DATA_W=16, RF_ADDR_W=4
- Sub-module rf_dump_seq:
  - contains the FSM, pointer, dump_valid and dump_done
  - outputs a pointer address to the top level, which performs the bypassed lookup and registers dump_data
- The storage array and read ports stay in rf_multiport, generated with a for-generate over NUM_RD.

Test Plan:
- Reset, then read every address on both ports -> rd_data = 0 one cycle later; dump_valid=0, dump_done=0.
- Write R3=16'hBEEF, next cycle read port0 addr 3 -> rd_data0=16'hBEEF after 1 cycle. Read R0 after writing 16'h1234 to addr 0 (ZERO_REG=1) -> 16'h0000.
- Same-edge write R5=16'hA5A5 with both ports reading addr 5 -> both rd_data = 16'hA5A5 at that edge (bypass). With re1=0, rd_data1 holds its old value.
- Preload Rn=16'h1000+n, pulse hlt for 1 cycle -> 15 consecutive dump_valid beats, addr 1..15, data 16'h1001..16'h100F. Then dump_done=1 sticky; a second hlt pulse causes no new beats.
- During the dump, write R9=16'hCAFE on the cycle the pointer is 9 -> beat for addr 9 shows 16'hCAFE. Assert rst_n=0 at beat 4 of a second run -> dump_valid=0 immediately, registers = 0, FSM in IDLE.
- NUM_RD=4, ADDR_W=3, ZERO_REG=0 build: dump yields 8 beats starting at addr 0; all four ports return correct independent addresses.
